// File: rtl/tile_frame_renderer_if.sv
// tile_frame_renderer_if: pixel write port with valid/ready backpressure.
interface tile_frame_renderer_if #(
   parameter int XY_W    = 9,
   parameter int COLOR_W = 9
);
   logic [XY_W-1:0]    px_x;
   logic [XY_W-1:0]    px_y;
   logic [COLOR_W-1:0] px_color;
   logic               px_valid;
   logic               px_ready;
   modport master(output px_x, px_y, px_color, px_valid, input px_ready);
   modport slave(input px_x, px_y, px_color, px_valid, output px_ready);
endinterface

// File: rtl/tile_frame_renderer.sv
// tile_frame_renderer: streams one full piano-tiles frame (clear, separators, clipped tiles, hitbox).
// Define TILE_RENDER_HITBOX_EN to include the hitbox band phase.
module tile_frame_renderer #(
   parameter int              WIDTH      = 160,
   parameter int              HEIGHT     = 120,
   parameter int              LANES      = 4,
   parameter int              ROWS       = 5,
   parameter int              TILE_H     = 30,
   parameter int              XY_W       = 9,
   parameter int              COLOR_W    = 9,
   parameter logic [COLOR_W-1:0] BG_COLOR   = 9'h1FF,
   parameter logic [COLOR_W-1:0] LINE_COLOR = 9'h000,
   parameter logic [COLOR_W-1:0] TILE_COLOR = 9'h000,
   parameter logic [COLOR_W-1:0] HIT_COLOR  = 9'h124,
   parameter logic [COLOR_W-1:0] HB_COLOR   = 9'h038,
   parameter int              HB_Y       = 100
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [ROWS*LANES-1:0]        keys,
   input  logic [XY_W-1:0]              yoffset,
   input  logic [$clog2(ROWS+1)-1:0]    num_hit,
   output logic                         busy,
   output logic                         done,
   tile_frame_renderer_if.master        px
);
   localparam int LANE_W = WIDTH / LANES;
   localparam int LB     = LANES > 1 ? $clog2(LANES) : 1;
   localparam int RB     = ROWS > 1 ? $clog2(ROWS) : 1;
   localparam int SW     = XY_W + 2;
   localparam int NHW    = $clog2(ROWS + 1);

   typedef enum logic [2:0] {
      IDLE, CLEAR, VLINES, ROW_SETUP, TILE,
`ifdef TILE_RENDER_HITBOX_EN
      HITBOX,
`endif
      DONE
   } state_t;

   state_t                  state_q;
   logic [ROWS*LANES-1:0]   keys_q;
   logic [XY_W-1:0]         yoff_q;
   logic [NHW-1:0]          nh_q;
   logic [RB-1:0]           r_q;
   logic [XY_W-1:0]         x_lo_q, x_hi_q, y_hi_q;
   logic [XY_W-1:0]         px_x_q, px_y_q;
   logic [COLOR_W-1:0]      color_q;
   logic                    valid_q, busy_q, done_q;

   logic [LANES-1:0]        row;
   logic [LB-1:0]           lane;
   logic signed [SW-1:0]    top, bot;
   logic [XY_W-1:0]         x_lo, x_hi, y_lo, y_hi;
   logic                    draw, last_row, xfer, adv;

   // Row geometry is evaluated for the current row index; only ROW_SETUP consumes it.
   always_comb begin
      row = keys_q[int'(r_q)*LANES +: LANES];
      lane = '0;
      for (int l = LANES - 1; l >= 0; l--) if (row[l]) lane = LB'(l);
      top = SW'(yoff_q) - SW'(r_q) * SW'(TILE_H);
      bot = top + SW'(TILE_H - 1);
      draw = (row != '0) && (bot >= 0) && (top <= SW'(HEIGHT - 1));
      y_lo = top < 0 ? '0 : XY_W'(top);
      y_hi = bot > SW'(HEIGHT - 1) ? XY_W'(HEIGHT - 1) : XY_W'(bot);
      x_lo = XY_W'(int'(lane) * LANE_W + 1);
      x_hi = XY_W'(int'(lane) * LANE_W + LANE_W - 1);
      last_row = int'(r_q) == ROWS - 1;
      xfer = valid_q && px.px_ready;
      adv = state_q == ROW_SETUP ? !draw
          : state_q == TILE && xfer && px_x_q == x_hi_q && px_y_q == y_hi_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         keys_q  <= '0;
         yoff_q  <= '0;
         nh_q    <= '0;
         r_q     <= '0;
         x_lo_q  <= '0;
         x_hi_q  <= '0;
         y_hi_q  <= '0;
         px_x_q  <= '0;
         px_y_q  <= '0;
         color_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               keys_q  <= keys;
               yoff_q  <= yoffset;
               nh_q    <= num_hit;
               px_x_q  <= '0;
               px_y_q  <= '0;
               color_q <= BG_COLOR;
               valid_q <= 1'b1;
               busy_q  <= 1'b1;
               state_q <= CLEAR;
            end
            CLEAR: if (xfer) begin
               if (px_x_q != XY_W'(WIDTH - 1)) px_x_q <= px_x_q + 1'b1;
               else if (px_y_q != XY_W'(HEIGHT - 1)) begin
                  px_x_q <= '0;
                  px_y_q <= px_y_q + 1'b1;
               end else if (LANES > 1) begin
                  px_x_q  <= XY_W'(LANE_W);
                  px_y_q  <= '0;
                  color_q <= LINE_COLOR;
                  state_q <= VLINES;
               end else begin
                  valid_q <= 1'b0;
                  r_q     <= '0;
                  state_q <= ROW_SETUP;
               end
            end
            VLINES: if (xfer) begin
               if (px_y_q != XY_W'(HEIGHT - 1)) px_y_q <= px_y_q + 1'b1;
               else if (px_x_q != XY_W'((LANES - 1) * LANE_W)) begin
                  px_y_q <= '0;
                  px_x_q <= px_x_q + XY_W'(LANE_W);
               end else begin
                  valid_q <= 1'b0;
                  r_q     <= '0;
                  state_q <= ROW_SETUP;
               end
            end
            ROW_SETUP: if (draw) begin
               x_lo_q  <= x_lo;
               x_hi_q  <= x_hi;
               y_hi_q  <= y_hi;
               px_x_q  <= x_lo;
               px_y_q  <= y_lo;
               color_q <= int'(r_q) < int'(nh_q) ? HIT_COLOR : TILE_COLOR;
               valid_q <= 1'b1;
               state_q <= TILE;
            end
            TILE: if (xfer) begin
               if (px_x_q != x_hi_q) px_x_q <= px_x_q + 1'b1;
               else if (px_y_q != y_hi_q) begin
                  px_x_q <= x_lo_q;
                  px_y_q <= px_y_q + 1'b1;
               end
            end
`ifdef TILE_RENDER_HITBOX_EN
            HITBOX: if (xfer) begin
               if (px_x_q != XY_W'(WIDTH - 1)) px_x_q <= px_x_q + 1'b1;
               else begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
`endif
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         // Finishing a row (skipped in setup or fully drawn) either moves on or closes the frame.
         if (adv) begin
            if (last_row) begin
`ifdef TILE_RENDER_HITBOX_EN
               px_x_q  <= '0;
               px_y_q  <= XY_W'(HB_Y);
               color_q <= HB_COLOR;
               valid_q <= 1'b1;
               state_q <= HITBOX;
`else
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
`endif
            end else begin
               r_q     <= r_q + 1'b1;
               valid_q <= 1'b0;
               state_q <= ROW_SETUP;
            end
         end
      end
   end

   assign px.px_x     = px_x_q;
   assign px.px_y     = px_y_q;
   assign px.px_color = color_q;
   assign px.px_valid = valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
endmodule

// File: tb/tb_tile_frame_renderer.sv
// tb_tile_frame_renderer: randomized frames checked against a loop-based frame model via a pixel scoreboard.
module tb_tile_frame_renderer;
   localparam int W = 40, H = 30, L = 4, R = 5, TH = 8, XW = 9, CW = 9, HBY = 25;
   localparam int LW = W / L, NHW = $clog2(R + 1), PW = 2 * XW + CW;
   localparam logic [CW-1:0] BG = 9'h1FF, LC = 9'h000, TC = 9'h000, HC = 9'h124, HBC = 9'h038;

   logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
   logic [R*L-1:0] keys = '0;
   logic [XW-1:0]  yoffset = '0;
   logic [NHW-1:0] num_hit = '0;
   logic busy, done;
   int passed = 0, total = 0, ready_pct = 100;
   logic [PW-1:0] exp_q[$];

   tile_frame_renderer_if #(.XY_W(XW), .COLOR_W(CW)) px();

   tile_frame_renderer #(
      .WIDTH(W), .HEIGHT(H), .LANES(L), .ROWS(R), .TILE_H(TH), .XY_W(XW), .COLOR_W(CW),
      .BG_COLOR(BG), .LINE_COLOR(LC), .TILE_COLOR(TC), .HIT_COLOR(HC), .HB_COLOR(HBC), .HB_Y(HBY)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .keys(keys), .yoffset(yoffset),
      .num_hit(num_hit), .busy(busy), .done(done), .px(px)
   );

   always #5 clk = ~clk;

   initial begin
      px.px_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 px.px_ready = $urandom_range(99) < ready_pct;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   function automatic logic [PW-1:0] pk(input int x, input int y, input logic [CW-1:0] c);
      return {XW'(x), XW'(y), c};
   endfunction

   // Reference frame: phases written as nested loops over the screen geometry.
   task automatic model(input logic [R*L-1:0] k, input int yo, input int nh);
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) exp_q.push_back(pk(x, y, BG));
      for (int s = 1; s < L; s++) for (int y = 0; y < H; y++) exp_q.push_back(pk(s * LW, y, LC));
      for (int r = 0; r < R; r++) begin
         logic [L-1:0] rowbits;
         int lane, t, b;
         rowbits = k[r*L +: L];
         if (rowbits == '0) continue;
         lane = 0;
         while (!rowbits[lane]) lane++;
         t = yo - r * TH;
         b = t + TH - 1;
         if (b < 0 || t > H - 1) continue;
         for (int y = (t < 0 ? 0 : t); y <= (b > H - 1 ? H - 1 : b); y++)
            for (int x = lane * LW + 1; x < (lane + 1) * LW; x++)
               exp_q.push_back(pk(x, y, r < nh ? HC : TC));
      end
`ifdef TILE_RENDER_HITBOX_EN
      for (int x = 0; x < W; x++) exp_q.push_back(pk(x, HBY, HBC));
`endif
   endtask

   // Monitor: pops on every accepted pixel and checks stall stability.
   logic hold = 1'b0;
   logic [PW-1:0] held, pix;
   always @(negedge clk) begin
      if (resetn) begin
         pix = {px.px_x, px.px_y, px.px_color};
         if (hold) begin
            check("stall_valid", 32'(px.px_valid), 1);
            check("stall_hold", 32'(pix), 32'(held));
         end
         hold = px.px_valid && !px.px_ready;
         held = pix;
         if (px.px_valid && px.px_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL pixel: got %0h expected none", pix);
            end else check("pixel", 32'(pix), 32'(exp_q.pop_front()));
         end
      end else hold = 1'b0;
   end

   task automatic issue(input logic [R*L-1:0] k, input int yo, input int nh, output int len);
      @(posedge clk);
      #1;
      keys = k;
      yoffset = XW'(yo);
      num_hit = NHW'(nh);
      start = 1'b1;
      model(k, yo, nh);
      len = exp_q.size() + R + 1;
      @(posedge clk);
      #1;
      start = 1'b0;
      keys = R*L'($urandom);
      yoffset = XW'($urandom);
      num_hit = NHW'($urandom_range(R));
   endtask

   task automatic run_frame(input logic [R*L-1:0] k, input int yo, input int nh, input int pct);
      int len, cyc;
      ready_pct = pct;
      issue(k, yo, nh, len);
      cyc = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (busy || done) cyc++;
         start = cyc == 100;
         if (done) break;
      end
      start = 1'b0;
      check("done_seen", 32'(done), 1);
      check("busy_at_done", 32'(busy), 0);
      if (pct == 100) check("frame_len", 32'(cyc), 32'(len));
      check("queue_drained", 32'(exp_q.size()), 0);
      exp_q.delete();
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("idle_valid", 32'(px.px_valid), 0);
      check("idle_busy", 32'(busy), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_x"}, 32'(px.px_x), 0);
      check({tag, "_y"}, 32'(px.px_y), 0);
      check({tag, "_color"}, 32'(px.px_color), 0);
      check({tag, "_valid"}, 32'(px.px_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
   endtask

   initial begin
      int len;
      logic [R*L-1:0] k;
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      resetn = 1'b1;
      run_frame('0, 0, 0, 100);
      run_frame(20'h00004, 25, 1, 60);
      run_frame(20'h10000, 28, 0, 100);
      run_frame(20'h000A0, 3, 2, 100);
      run_frame(20'hFFFFF, 30, 5, 60);
      run_frame(20'h12345, 200, 3, 100);
      // Abort in the separator phase, then a fresh frame must be complete.
      ready_pct = 100;
      issue(20'h00421, 12, 1, len);
      repeat (W * H + 5) @(negedge clk);
      check("in_vlines_x", 32'(px.px_x), LW);
      #1 resetn = 1'b0;
      #1 check_zero("abort");
      exp_q.delete();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      run_frame(20'h00421, 12, 1, 100);
      for (int i = 0; i < 10; i++) begin
         for (int r = 0; r < R; r++) k[r*L +: L] = $urandom_range(9) < 3 ? '0 : L'($urandom);
         run_frame(k, $urandom_range(H + R * TH + 10), $urandom_range(R), i % 2 ? 100 : $urandom_range(30, 90));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/tile_frame_renderer.md
# tile_frame_renderer

Parametrised full-frame renderer for the piano-tiles display. On a `start` pulse it captures a snapshot of the tile state and streams every pixel write of one frame to the VGA write port, one pixel per accepted cycle. A frame is drawn in this order: background clear, lane separators, clipped tiles, then hitbox band. It generalises the fixed 4-lane, 5-row engine to arbitrary lane/row counts, adds a valid/ready backpressure handshake on the pixel port, and clips partially visible tiles at both screen edges.

## Interface
- `WIDTH`, 160: screen width in pixels.
- `HEIGHT`, 120: screen height in pixels.
- `LANES`, 4: lane count; must divide `WIDTH`; `LANE_W = WIDTH/LANES`.
- `ROWS`, 5: tile rows tracked.
- `TILE_H`, 30: tile height in pixels.
- `XY_W`, 9: coordinate width.
- `COLOR_W`, 9: colour width.
- `BG_COLOR`, 9'h1FF: clear colour.
- `LINE_COLOR`, 9'h000: separator colour.
- `TILE_COLOR`, 9'h000: unhit tile colour.
- `HIT_COLOR`, 9'h124: hit tile colour.
- `HB_COLOR`, 9'h038: hitbox colour.
- `HB_Y`, 100: hitbox row.

Ports:
- `clk`, in, 1: clock, rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: frame request; sampled only in IDLE.
- `keys`, in, `ROWS*LANES`: row r = `keys[r*LANES +: LANES]`; row 0 is the bottom row.
- `yoffset`, in, `XY_W`: top y of row 0 (unsigned).
- `num_hit`, in, `$clog2(ROWS+1)`: rows 0..num_hit-1 use `HIT_COLOR`.
- `px_x`, `px_y`, out, `XY_W`: pixel coordinate.
- `px_color`, out, `COLOR_W`: pixel colour.
- `px_valid`, out, 1: a pixel is presented.
- `px_ready`, in, 1: the sink accepts the pixel.
- `busy`, out, 1: high from start acceptance until `done`.
- `done`, out, 1: one-cycle pulse at end of frame.

## Operation
- States: IDLE → CLEAR → VLINES → ROW_SETUP ⇄ TILE → HITBOX → DONE → IDLE.
- IDLE:
  - When `start`=1, register `keys`, `yoffset` and `num_hit`, then go to CLEAR.
  - Inputs are ignored at all other times; `start` while `busy` is dropped.
- CLEAR:
  - Raster scan of every pixel, x fastest: (0,0), (1,0) … (WIDTH-1,HEIGHT-1).
  - Colour is `BG_COLOR`.
- VLINES:
  - For k = 1..LANES-1: x = k·LANE_W, y = 0..HEIGHT-1, colour `LINE_COLOR`.
  - With LANES=1 this phase is skipped, costing zero cycles.
- ROW_SETUP, one cycle per row r = 0..ROWS-1, `px_valid`=0:
  - Lane = lowest set bit of row r.
  - top = yoffset − r·TILE_H, computed signed in XY_W+2 bits.
  - bot = top + TILE_H − 1.
  - Clip the span to [0, HEIGHT-1].
  - If the row is empty or fully off-screen, advance r (to HITBOX after the last row); otherwise go to TILE.
- TILE:
  - x = lane·LANE_W+1 .. (lane+1)·LANE_W−1, for y = clipped top..bot, raster order.
  - Colour is `HIT_COLOR` if r < num_hit, else `TILE_COLOR`.
- HITBOX: x = 0..WIDTH-1 at y = `HB_Y`, colour `HB_COLOR`.
- DONE: `done`=1 for one cycle, `busy` drops the same cycle, then IDLE.

## Timing
- Reset (asynchronous): state IDLE; `px_x`=`px_y`=0, `px_color`=0, `px_valid`=0, `busy`=0, `done`=0; the snapshot is cleared to 0.
- `start` sampled high at edge t: `busy`=1 and `px_valid`=1 with pixel (0,0) from edge t+1.
- Pixel handshake:
  - A transfer occurs on an edge where `px_valid`&&`px_ready`.
  - While `px_valid`=1 and `px_ready`=0, x/y/colour hold stable.
  - `px_valid` never drops without a transfer, except across ROW_SETUP and DONE.
- No bubble between CLEAR, VLINES, the first ROW_SETUP, and HITBOX-after-setup.
- Frame length with `px_ready`=1: W·H + (LANES−1)·H + ROWS + tile pixels + W(hitbox) + 1 (DONE) cycles.
- Asserting `resetn` mid-frame aborts the frame immediately; no `done` is produced.

## Configuration
- `TILE_RENDER_HITBOX_EN` defined: the HITBOX phase is present as specified.
- Undefined:
  - The HITBOX state and `HB_*` logic are absent; the last ROW_SETUP goes directly to DONE.
  - The frame is W cycles shorter.

## Test plan
- Defaults, keys=0, ready=1, start → 19200 BG pixels, then 360 separator pixels (x=40/80/120), 5 idle setup cycles, 160 green pixels at y=100; `done` at cycle 19726 after start.
- Row 0 lane 2, yoffset=100, num_hit=1 → 780 pixels, x 81..119, y 100..119, all 9'h124.
- Row 4 lane 0, yoffset=100 (top=−20) → y 0..9 only, x 1..39, 390 pixels of 9'h000.
- Row 1 with keys 4'b1010, yoffset=10 → only lane 1 drawn; span clipped to y 0..9.
- Toggle `px_ready` pseudo-randomly → sink-captured pixel sequence identical to the ready=1 run; held outputs stable during stalls; `start` mid-frame ignored.
- `resetn` low during VLINES → all outputs 0 that cycle; a fresh start afterwards yields a correct full frame.
